// File: rtl/ysyx_24100006_memu_pkg.sv
// Shared memory-unit definitions.
// Holds the MEMU state encoding and the sram_read_write / Mem_Mask encodings
// that decode and EXE also produce, plus small helpers for alignment checks
// and store-lane formatting.
package ysyx_24100006_memu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } memu_state_e;

    // 2'b11 is reserved and behaves like RW_NONE.
    typedef enum logic [1:0] {
        RW_NONE  = 2'b00,
        RW_LOAD  = 2'b01,
        RW_STORE = 2'b10,
        RW_RSVD  = 2'b11
    } sram_rw_e;

    typedef enum logic [2:0] {
        MASK_LB  = 3'b000,
        MASK_LH  = 3'b001,
        MASK_LW  = 3'b010,
        MASK_LBU = 3'b100,
        MASK_LHU = 3'b101
    } mem_mask_e;

    // Access size lives in Mem_Mask[1:0] for both loads and stores.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [2:0] mask, input logic [1:0] a);
        logic mis;
        case (mask[1:0])
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] mask, input logic [1:0] a);
        logic [3:0] s;
        case (mask[1:0])
            SZ_BYTE: s = 4'b0001 << a;
            SZ_HALF: s = 4'b0011 << a;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Data is replicated across lanes so the strobes alone select the bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] mask, input logic [31:0] d);
        logic [31:0] w;
        case (mask[1:0])
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ysyx_24100006_load_align.sv
// Load alignment and extension (purely combinational).
// Ports:
//   rdata    in  32  word returned by the bus
//   a        in  2   byte offset of the access (addr[1:0])
//   mem_mask in  3   Mem_Mask encoding (LB/LH/LW/LBU/LHU)
//   result   out 32  aligned, sign- or zero-extended load value
module ysyx_24100006_load_align
    import ysyx_24100006_memu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  mem_mask,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        case (mem_mask)
            MASK_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            MASK_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            MASK_LW:  result = shifted;
            MASK_LBU: result = {24'h0, shifted[7:0]};
            MASK_LHU: result = {16'h0, shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_24100006_memu.sv
// MEM stage unit: takes one instruction from the EXE/MEM register, issues at
// most one bus transaction for it, and hands the result to MEM/WB.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready        upstream handshake; alu_result_i, sram_read_write_i,
//                            Mem_Mask_i, wdata_gpr_i, sb_i are the instruction
//   flush_i                  kill the instruction held or in flight
//   out_valid/out_ready      downstream handshake; wdata_gpr_o, sb_o,
//                            access_fault_o qualified by out_valid
//   mem_req_*                word-aligned bus request (valid/ready)
//   mem_rsp_*                single-cycle bus response
module ysyx_24100006_memu
    import ysyx_24100006_memu_pkg::*;
#(
    parameter int unsigned SB_W = 48
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     alu_result_i,
    input  logic [1:0]      sram_read_write_i,
    input  logic [2:0]      Mem_Mask_i,
    input  logic [31:0]     wdata_gpr_i,
    input  logic [SB_W-1:0] sb_i,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     wdata_gpr_o,
    output logic [SB_W-1:0] sb_o,
    output logic            access_fault_o,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [31:0]     mem_req_addr,
    output logic [31:0]     mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_rdata,
    input  logic            mem_rsp_err
);

    memu_state_e     state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      rw_q, rw_d;
    logic [2:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [SB_W-1:0] sb_q, sb_d;
    logic [31:0]     result_q, result_d;
    logic            fault_q, fault_d;
    logic            kill_q, kill_d;

    logic            accept;
    logic            is_mem;
    logic [31:0]     load_data;

    ysyx_24100006_load_align u_load_align (
        .rdata    (mem_rsp_rdata),
        .a        (addr_q[1:0]),
        .mem_mask (mask_q),
        .result   (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rw_q     <= '0;
            mask_q   <= '0;
            wdata_q  <= '0;
            sb_q     <= '0;
            result_q <= '0;
            fault_q  <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            mask_q   <= mask_d;
            wdata_q  <= wdata_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            fault_q  <= fault_d;
            kill_q   <= kill_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        sb_d     = sb_q;
        result_d = result_q;
        fault_d  = fault_q;
        kill_d   = kill_q;
        accept   = 1'b0;
        is_mem   = (sram_read_write_i == RW_LOAD) || (sram_read_write_i == RW_STORE);

        case (state_q)
            ST_IDLE: begin
                if (!flush_i && in_valid) accept = 1'b1;
            end
            ST_REQ: begin
                // A flush cannot withdraw an issued request; remember it instead.
                if (flush_i) kill_d = 1'b1;
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    if (kill_q || flush_i) begin
                        state_d = ST_IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = (rw_q == RW_LOAD) ? load_data : wdata_q;
                        fault_d  = mem_rsp_err;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                    if (in_valid) accept = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the release path above so DONE can refill in one cycle.
        if (accept) begin
            addr_d  = alu_result_i;
            rw_d    = sram_read_write_i;
            mask_d  = Mem_Mask_i;
            wdata_d = wdata_gpr_i;
            sb_d    = sb_i;
            kill_d  = 1'b0;
            if (is_mem) begin
                if (is_misaligned(Mem_Mask_i, alu_result_i[1:0])) begin
                    state_d  = ST_DONE;
                    fault_d  = 1'b1;
                    result_d = (sram_read_write_i == RW_STORE) ? wdata_gpr_i : '0;
                end else begin
                    state_d = ST_REQ;
                    fault_d = 1'b0;
                end
            end else begin
                state_d  = ST_DONE;
                fault_d  = 1'b0;
                result_d = wdata_gpr_i;
            end
        end
    end

    // Outputs
    always_comb begin
        in_ready       = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid      = (state_q == ST_DONE);
        wdata_gpr_o    = result_q;
        sb_o           = sb_q;
        access_fault_o = fault_q;
        mem_req_valid  = (state_q == ST_REQ);
        mem_req_wen    = (rw_q == RW_STORE);
        mem_req_addr   = {addr_q[31:2], 2'b00};
        mem_req_wdata  = store_wdata(mask_q, wdata_q);
        mem_req_wstrb  = mem_req_wen ? store_strb(mask_q, addr_q[1:0]) : 4'b0000;
    end

endmodule
